// File: rtl/stream_mux_n_1.sv
// stream_mux_n_1: N:1 valid/ready stream mux with registered output; define STREAM_MUX_RR_EN for round-robin mode
module stream_mux_n_1 #(
   parameter int N = 4,
   parameter int W = 4,
   localparam int SW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    in_valid_i,
   input  logic [N*W-1:0]  in_data_i,
   output logic [N-1:0]    in_ready_o,
   input  logic [SW-1:0]   sel_i,
`ifdef STREAM_MUX_RR_EN
   input  logic            rr_mode_i,
`endif
   output logic            out_valid_o,
   output logic [W-1:0]    out_data_o,
   output logic [SW-1:0]   out_chan_o,
   input  logic            out_ready_i
);
   logic          out_valid_q, out_valid_d;
   logic [W-1:0]  out_data_q, out_data_d;
   logic [SW-1:0] out_chan_q, out_chan_d;
   logic [SW-1:0] g;
   logic          can_load, xfer;
   assign can_load = !out_valid_q || out_ready_i;
`ifdef STREAM_MUX_RR_EN
   logic [SW-1:0] ptr_q, ptr_d, rr_g;
   // first valid channel at or after ptr, wrapping; highest offset first so the nearest wins
   always_comb begin
      rr_g = ptr_q;
      for (int i = N - 1; i >= 0; i--)
         if (in_valid_i[(int'(ptr_q) + i) % N]) rr_g = SW'((int'(ptr_q) + i) % N);
   end
   assign g     = rr_mode_i ? rr_g : sel_i;
   assign ptr_d = (rr_mode_i && xfer) ? ((int'(g) == N - 1) ? '0 : g + SW'(1)) : ptr_q;
   // pointer advances past the channel just served
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) ptr_q <= '0;
      else ptr_q <= ptr_d;
`else
   assign g = sel_i;
`endif
   // one-hot ready on the granted channel; out-of-range index and reset grant nothing
   always_comb begin
      in_ready_o = '0;
      if (rst_n && can_load && int'(g) < N) in_ready_o[g] = 1'b1;
   end
   assign xfer = |(in_valid_i & in_ready_o);
   // output register next state: load on input transfer, empty on lone output transfer
   always_comb begin
      out_valid_d = xfer ? 1'b1 : (out_ready_i ? 1'b0 : out_valid_q);
      out_data_d  = xfer ? in_data_i[int'(g) * W +: W] : out_data_q;
      out_chan_d  = xfer ? g : out_chan_q;
   end
   // output stage registers
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_chan_q  <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
      end
   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
   assign out_chan_o  = out_chan_q;
endmodule
